gsa_accum_ctrl: RTL

//  Sequencer for the growing-sum-average bin collector. Frames FFT bin stream on fft_valid.

---
 rtl/gsa_pkg.sv | 20 ++
 rtl/gsa_accum_ctrl_if.sv | 36 +++
 rtl/gsa_accum_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/gsa_pkg.sv
// Shared types and widths for the growing-sum-average bin collector.
// Imported by the sequencer and the collector datapath.
package gsa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ACCUM,
    DUMP
  } gsa_state_t;

  localparam int GSA_BINS     = 4;
  localparam int GSA_MAX_LOG2 = 15;
  localparam int GSA_BIN_W    = $clog2(GSA_BINS);
  localparam int GSA_K_W      = $clog2(GSA_MAX_LOG2 + 1);
  localparam int GSA_DROP_W   = 8;

  localparam logic [GSA_DROP_W-1:0] GSA_DROP_MAX = '1;

endpackage

// File: rtl/gsa_accum_ctrl_if.sv
// Datapath control and dump handshake between the sequencer
// and the collector / readout path.
interface gsa_accum_ctrl_if #(
  parameter int BINS     = 4,
  parameter int MAX_LOG2 = 15
);

  localparam int BW = $clog2(BINS);
  localparam int KW = $clog2(MAX_LOG2 + 1);

  logic          acc_en;
  logic          acc_clr;
  logic [BW-1:0] bin_idx;
  logic          out_valid;
  logic          out_ready;
  logic [KW-1:0] out_shift;

  modport master (
    output acc_en,
    output acc_clr,
    output bin_idx,
    output out_valid,
    output out_shift,
    input  out_ready
  );

  modport slave (
    input  acc_en,
    input  acc_clr,
    input  bin_idx,
    input  out_valid,
    input  out_shift,
    output out_ready
  );

endinterface

// File: rtl/gsa_accum_ctrl.sv
// Sequencer for the growing-sum-average collector: frames the FFT
// bin stream, counts 2^k frames, then holds a dump for readout.
module gsa_accum_ctrl
  import gsa_pkg::*;
#(
  parameter int BINS     = GSA_BINS,
  parameter int MAX_LOG2 = GSA_MAX_LOG2,
  localparam int BW      = $clog2(BINS),
  localparam int KW      = $clog2(MAX_LOG2 + 1)
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  cfg_cont,
  input  logic [KW-1:0]         cfg_avg_log2,
  input  logic                  fft_valid,
  gsa_accum_ctrl_if.master      dp,
  output logic                  busy,
  output logic                  err_overrun,
  output logic [GSA_DROP_W-1:0] drop_cnt
);

  localparam logic [BW-1:0] BIN_LAST = BW'(BINS - 1);
  localparam logic [KW-1:0] K_MAX    = KW'(MAX_LOG2);

  gsa_state_t state_q, state_d;

  logic [BW-1:0]         bin_q, bin_d;
  logic [MAX_LOG2-1:0]   frame_q, frame_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  ov_q, ov_d;
  logic                  err_q, err_d;
  logic [GSA_DROP_W-1:0] drop_q, drop_d;

  logic [KW-1:0]       k_clamp;
  logic [MAX_LOG2:0]   frame_tgt;
  logic                frame_last;
  logic                first_frame;

  assign k_clamp = (cfg_avg_log2 > K_MAX) ? K_MAX : cfg_avg_log2;

  // One extra bit so k=MAX_LOG2 still yields an all-ones target.
  assign frame_tgt   = ({{MAX_LOG2{1'b0}}, 1'b1} << k_q) - 1'b1;
  assign frame_last  = ({1'b0, frame_q} == frame_tgt);
  assign first_frame = (frame_q == '0);

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      frame_q <= '0;
      k_q     <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      frame_q <= frame_d;
      k_q     <= k_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    frame_d    = frame_q;
    k_d        = k_q;
    ov_d       = ov_q;
    err_d      = err_q;
    drop_d     = drop_q;
    dp.acc_en  = 1'b0;
    dp.acc_clr = 1'b0;
    dp.bin_idx = '0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = ARM;
          k_d     = k_clamp;
          frame_d = '0;
          bin_d   = '0;
          err_d   = 1'b0;
          drop_d  = '0;
        end
      end
      ARM: begin
        if (fft_valid) begin
          dp.acc_en  = 1'b1;
          dp.acc_clr = first_frame;
          bin_d      = BW'(1);
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        dp.acc_en  = 1'b1;
        dp.acc_clr = first_frame;
        dp.bin_idx = bin_q;
        // A new frame marker mid-frame is flagged, not resynced.
        if (fft_valid) err_d = 1'b1;
        if (bin_q == BIN_LAST) begin
          bin_d = '0;
          if (frame_last) begin
            state_d = DUMP;
            ov_d    = 1'b1;
          end else begin
            frame_d = frame_q + 1'b1;
            state_d = ARM;
          end
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end
      DUMP: begin
        if (fft_valid && drop_q != GSA_DROP_MAX)
          drop_d = drop_q + 1'b1;
        if (ov_q && dp.out_ready) begin
          ov_d    = 1'b0;
          frame_d = '0;
          state_d = cfg_cont ? ARM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop) begin
      state_d = IDLE;
      ov_d    = 1'b0;
      bin_d   = '0;
    end
  end

  assign dp.out_valid = ov_q;
  assign dp.out_shift = k_q;
  assign busy         = (state_q != IDLE);
  assign err_overrun  = err_q;
  assign drop_cnt     = drop_q;

endmodule
